// File: rtl/gpr_bank_responder.sv
// gpr_bank_responder
// Responder side of the stage-to-register-file request/response link.
// Holds the x86 general-purpose register bank and answers NOP/READ/WRITE/XCHG
// commands with one registered response per non-NOP command, held until taken.
module gpr_bank_responder #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    NUM_REGS   = 8,
    parameter int                    REG_IDX_W  = 4,
    parameter int                    CMD_W      = 2,
    parameter int                    SP_INDEX   = 4,
    parameter logic [DATA_WIDTH-1:0] SP_RESET   = 32'h0000_FFFC
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_IDX_W-1:0]  i_reg,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic [CMD_W-1:0]      i_cmd,
    input  logic                  i_valid,
    input  logic                  i_res_ready,
    output logic                  o_ready,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_res_valid,
    output logic                  o_err
);

    localparam int BANK_IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    localparam logic [CMD_W-1:0] CMD_NOP   = CMD_W'(2'b00);
    localparam logic [CMD_W-1:0] CMD_READ  = CMD_W'(2'b01);
    localparam logic [CMD_W-1:0] CMD_WRITE = CMD_W'(2'b10);
    localparam logic [CMD_W-1:0] CMD_XCHG  = CMD_W'(2'b11);

    // One extra bit so the bound itself always fits, whatever NUM_REGS is.
    localparam logic [REG_IDX_W:0] NUM_REGS_BOUND = (REG_IDX_W + 1)'(NUM_REGS);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } state_t;

    state_t                  state_r;
    state_t                  state_nxt_s;
    logic [DATA_WIDTH-1:0]   bank_r [NUM_REGS];
    logic [DATA_WIDTH-1:0]   data_r;
    logic                    err_r;

    logic                    ready_s;
    logic                    accept_s;
    logic                    resp_accept_s;
    logic                    in_range_s;
    logic                    bank_we_s;
    logic [BANK_IDX_W-1:0]   bank_idx_s;
    logic [DATA_WIDTH-1:0]   rd_data_s;
    logic [DATA_WIDTH-1:0]   resp_data_s;

    // Handshake decode: readiness, accept qualification and bank read port.
    always_comb begin
        ready_s       = 1'b0;
        accept_s      = 1'b0;
        resp_accept_s = 1'b0;
        bank_we_s     = 1'b0;
        rd_data_s     = {DATA_WIDTH{1'b0}};
        in_range_s    = ({1'b0, i_reg} < NUM_REGS_BOUND);
        bank_idx_s    = i_reg[BANK_IDX_W-1:0];

        // Nothing is accepted while reset is applied.
        if (!reset) begin
            ready_s = 1'b0;
        end else begin
            ready_s = (state_r == ST_IDLE) || i_res_ready;
        end

        accept_s      = i_valid && ready_s;
        resp_accept_s = accept_s && (i_cmd != CMD_NOP);
        bank_we_s     = accept_s && in_range_s &&
                        ((i_cmd == CMD_WRITE) || (i_cmd == CMD_XCHG));

        // Out-of-range indices read as zero.
        if (in_range_s) begin
            rd_data_s = bank_r[bank_idx_s];
        end else begin
            rd_data_s = {DATA_WIDTH{1'b0}};
        end
    end

    // Response payload selection for the accepted command.
    always_comb begin
        resp_data_s = {DATA_WIDTH{1'b0}};
        case (i_cmd)
            CMD_READ:  resp_data_s = rd_data_s;
            CMD_WRITE: resp_data_s = i_data;
            CMD_XCHG:  resp_data_s = rd_data_s;
            CMD_NOP:   resp_data_s = {DATA_WIDTH{1'b0}};
            default:   resp_data_s = {DATA_WIDTH{1'b0}};
        endcase
    end

    // Next-state logic: a response stays pending until taken, and a new
    // non-NOP accept in the same cycle keeps the FSM in ST_RESP.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (resp_accept_s) begin
                    state_nxt_s = ST_RESP;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RESP: begin
                if (resp_accept_s) begin
                    state_nxt_s = ST_RESP;
                end else if (i_res_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RESP;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State register; reset drops any pending response.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Register bank: reset image has only ESP non-zero; writes commit at accept.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (i == SP_INDEX) begin
                    bank_r[i] <= SP_RESET;
                end else begin
                    bank_r[i] <= {DATA_WIDTH{1'b0}};
                end
            end
        end else if (bank_we_s) begin
            bank_r[bank_idx_s] <= i_data;
        end
    end

    // Response payload registers, only loaded by a non-NOP accept so they
    // stay stable under backpressure.
    always_ff @(posedge clk) begin
        if (!reset) begin
            data_r <= {DATA_WIDTH{1'b0}};
            err_r  <= 1'b0;
        end else if (resp_accept_s) begin
            data_r <= resp_data_s;
            err_r  <= !in_range_s;
        end
    end

    assign o_ready     = ready_s;
    assign o_res_valid = (state_r == ST_RESP);
    assign o_data      = data_r;
    assign o_err       = err_r;

endmodule
